// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU.
// Opcodes, FSM states and the registered flag bundle.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic cout;
    logic overflow;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit adder/subtractor: a+b or a+~b+1.
// Reports MSB carry-out and signed overflow.
module alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  // Invert b and inject carry-in for subtraction;
  // overflow when effective operand signs agree
  // but the result sign differs from a.
  always_comb begin
    b_eff    = sub ? ~b : b;
    full     = {1'b0, a} + {1'b0, b_eff}
             + {{WIDTH{1'b0}}, sub};
    sum      = full[WIDTH-1:0];
    cout     = full[WIDTH];
    overflow = (a[WIDTH-1] == b_eff[WIDTH-1])
            && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: one-step logic ops, shift-add mul.
// Multiplier built only when ALU_MUL_EN is defined.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             illegal
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  alu_flags_t       flags_q, flags_d;
  logic             zero_q, zero_d;

  logic             as_sub;
  logic [WIDTH-1:0] as_sum;
  logic             as_cout;
  logic             as_ovf;

  logic [WIDTH-1:0] res_out;
  alu_flags_t       res_f;
  logic             mul_sel;

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     mul_hi;
  logic [2*WIDTH-1:0] prod_step;
`endif

  assign as_sub = (op != OP_ADD);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (a),
    .b        (b),
    .sub      (as_sub),
    .sum      (as_sum),
    .cout     (as_cout),
    .overflow (as_ovf)
  );

  // Single-step result for the op on the inputs.
  always_comb begin
    res_out = '0;
    res_f   = '0;
    mul_sel = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        res_out        = as_sum;
        res_f.cout     = as_cout;
        res_f.overflow = as_ovf;
      end
      OP_XOR: res_out = a ^ b;
      OP_SLT: res_out =
        WIDTH'(as_sum[WIDTH-1] ^ as_ovf);
      OP_AND: res_out = a & b;
      OP_OR:  res_out = a | b;
`ifdef ALU_MUL_EN
      OP_MUL: mul_sel = 1'b1;
`endif
      default: res_f.illegal = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  // One shift-add step: add multiplicand into the
  // upper half when the low bit is set, shift right.
  always_comb begin
    mul_hi = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
           + (prod_q[0] ? {1'b0, mcand_q}
                        : {(WIDTH+1){1'b0}});
    prod_step = {mul_hi, prod_q[WIDTH-1:1]};
  end
`else
  logic unused_mul;
  assign unused_mul = mul_sel;
`endif

  // FSM next-state and result capture.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    flags_d = flags_q;
    zero_d  = zero_q;
`ifdef ALU_MUL_EN
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef ALU_MUL_EN
          if (mul_sel) begin
            state_d = ST_BUSY;
            mcand_d = a;
            prod_d  = {{WIDTH{1'b0}}, b};
            cnt_d   = '0;
          end else
`endif
          begin
            state_d = ST_DONE;
            out_d   = res_out;
            flags_d = res_f;
            zero_d  = (res_out == '0);
          end
        end
      end
`ifdef ALU_MUL_EN
      ST_BUSY: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d          = ST_DONE;
          out_d            = prod_step[WIDTH-1:0];
          flags_d          = '0;
          flags_d.overflow =
            |prod_step[2*WIDTH-1:WIDTH];
          zero_d = (prod_step[WIDTH-1:0] == '0);
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      flags_q <= '0;
      zero_q  <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      flags_q <= flags_d;
      zero_q  <= zero_d;
`ifdef ALU_MUL_EN
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;
  assign cout      = flags_q.cout;
  assign overflow  = flags_q.overflow;
  assign illegal   = flags_q.illegal;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32).
// Honours ALU_MUL_EN for the multiply expectations.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic        cout, overflow, zero, illegal;
  logic [31:0] a = '0, b = '0, out;
  logic [2:0]  op = '0;

  int errs = 0;
  int checks = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  // Reference: arithmetic on 64-bit integers.
  function automatic void model(
    input  logic [2:0]  o,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [35:0] v,
    output int          lat
  );
    longint sx, sy, s;
    logic [63:0] u;
    logic [31:0] r;
    logic c, ov, il;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0; c = 0; ov = 0; il = 0; lat = 1;
    case (o)
      3'd0: begin
        u = 64'(x) + 64'(y);
        r = u[31:0]; c = u[32];
        s = sx + sy; ov = (s > MAXS) || (s < MINS);
      end
      3'd1: begin
        r = x - y; c = (x >= y);
        s = sx - sy; ov = (s > MAXS) || (s < MINS);
      end
      3'd2: r = x ^ y;
      3'd3: r = (sx < sy) ? 32'd1 : 32'd0;
      3'd4: r = x & y;
      3'd5: r = x | y;
`ifdef ALU_MUL_EN
      3'd6: begin
        u = 64'(x) * 64'(y);
        r = u[31:0]; ov = (u[63:32] != 0); lat = 33;
      end
`endif
      default: il = 1;
    endcase
    v = {r, c, ov, (r == 0), il};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [35:0] obs();
    return {out, cout, overflow, zero, illegal};
  endfunction

  // Present one op, wait (bounded) for out_valid.
  task automatic issue(
    input  logic [2:0]  o,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  bit          noise,
    output int          lat,
    output bit          rdy_busy
  );
    @(negedge clk);
    a = x; b = y; op = o; in_valid = 1'b1;
    @(negedge clk);
    lat = 1; rdy_busy = 0;
    if (!noise) in_valid = 1'b0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready) rdy_busy = 1;
      if (noise) begin
        a = $urandom; b = $urandom;
        op = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic retire(output bit rdy, output bit ov);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rdy = in_ready; ov = out_valid;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errs++;
      $display("FAIL reset_hs: got %b want 10",
               {in_ready, out_valid});
    end
    checks++;
    if (obs() !== 36'h0) begin
      errs++;
      $display("FAIL reset_out: got %h want 0",
               obs());
    end
    reset = 1'b1; in_valid = 1'b1; op = 3'd0;
    a = 32'h5; b = 32'h6;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errs++;
      $display("FAIL reset_prio: got %b want 10",
               {in_ready, out_valid});
    end
    reset = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_add();
    int lat; bit rb, rdy, ov;
    issue(3'd0, 32'hFFFF_FFFF, 32'h1, 0, lat, rb);
    checks++;
    if (lat !== 1) begin
      errs++;
      $display("FAIL add_lat: got %0d want 1", lat);
    end
    checks++;
    if (obs() !== {32'h0, 4'b1010}) begin
      errs++;
      $display("FAIL add_wrap: got %h want %h",
               obs(), {32'h0, 4'b1010});
    end
    retire(rdy, ov);
    checks++;
    if ({rdy, ov} !== 2'b10) begin
      errs++;
      $display("FAIL add_retire: got %b want 10",
               {rdy, ov});
    end
    issue(3'd0, 32'hB000_0000, 32'hC000_0001,
          0, lat, rb);
    checks++;
    if (obs() !== {32'h7000_0001, 4'b1100}) begin
      errs++;
      $display("FAIL add_ovf: got %h want %h",
               obs(), {32'h7000_0001, 4'b1100});
    end
    retire(rdy, ov);
  endtask

  task automatic test_sub_slt();
    int lat; bit rb, rdy, ov;
    issue(3'd1, 32'h8000_0000, 32'h4000_0001,
          0, lat, rb);
    checks++;
    if (obs() !== {32'h3FFF_FFFF, 4'b1100}) begin
      errs++;
      $display("FAIL sub_ovf: got %h want %h",
               obs(), {32'h3FFF_FFFF, 4'b1100});
    end
    retire(rdy, ov);
    issue(3'd3, 32'h8000_0000, 32'h4000_0001,
          0, lat, rb);
    checks++;
    if (obs() !== {32'h1, 4'b0000}) begin
      errs++;
      $display("FAIL slt: got %h want %h",
               obs(), {32'h1, 4'b0000});
    end
    retire(rdy, ov);
  endtask

  task automatic test_mul();
    int lat; bit rb, rdy, ov;
    logic [35:0] exp_v;
    int exp_lat;
    issue(3'd6, 32'h0001_0000, 32'h0001_0000,
          0, lat, rb);
`ifdef ALU_MUL_EN
    exp_v = {32'h0, 4'b0110}; exp_lat = 33;
`else
    exp_v = {32'h0, 4'b0011}; exp_lat = 1;
`endif
    checks++;
    if (lat !== exp_lat || rb !== 1'b0) begin
      errs++;
      $display("FAIL mul_lat: got %0d/%b want %0d/0",
               lat, rb, exp_lat);
    end
    checks++;
    if (obs() !== exp_v) begin
      errs++;
      $display("FAIL mul_res: got %h want %h",
               obs(), exp_v);
    end
    retire(rdy, ov);
  endtask

  task automatic test_illegal_ignore();
    int lat, el; bit rb, rdy, ov;
    logic [35:0] ev;
    issue(3'd7, 32'h1234_5678, 32'h9, 0, lat, rb);
    checks++;
    if (obs() !== {32'h0, 4'b0011}) begin
      errs++;
      $display("FAIL illegal: got %h want %h",
               obs(), {32'h0, 4'b0011});
    end
    retire(rdy, ov);
    model(3'd6, 32'd3, 32'd5, ev, el);
    issue(3'd6, 32'd3, 32'd5, 1, lat, rb);
    checks++;
    if (obs() !== ev || lat !== el) begin
      errs++;
      $display("FAIL ignore: got %h/%0d want %h/%0d",
               obs(), lat, ev, el);
    end
    retire(rdy, ov);
  endtask

  task automatic test_hold();
    int lat; bit rb, rdy, ov;
    logic [35:0] ev;
    issue(3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0,
          0, lat, rb);
    ev = {32'hFF00_FF00, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 3'd0;
      a = $urandom; b = $urandom;
      checks++;
      if (obs() !== ev || out_valid !== 1'b1
          || in_ready !== 1'b0) begin
        errs++;
        $display("FAIL hold%0d: got %h v%b r%b want %h",
                 i, obs(), out_valid, in_ready, ev);
      end
      @(negedge clk);
    end
    retire(rdy, ov);
    checks++;
    if ({rdy, ov} !== 2'b10) begin
      errs++;
      $display("FAIL hold_release: got %b want 10",
               {rdy, ov});
    end
  endtask

  task automatic test_reset_busy();
    bit bad;
`ifdef ALU_MUL_EN
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    op = 3'd6; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
`else
    int lat; bit rb;
    issue(3'd0, 32'h7, 32'h8, 0, lat, rb);
`endif
    reset = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10
        || obs() !== 36'h0) begin
      errs++;
      $display("FAIL rst_busy: got r%b v%b %h want 1 0 0",
               in_ready, out_valid, obs());
    end
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad = 1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errs++;
      $display("FAIL rst_nopulse: got %b want 0", bad);
    end
  endtask

  task automatic test_random();
    int lat, el; bit rb, rdy, ov;
    logic [35:0] ev;
    logic [31:0] x, y;
    logic [2:0] o;
    for (int i = 0; i < 150; i++) begin
      x = pick(); y = pick();
      o = 3'($urandom_range(0, 7));
      model(o, x, y, ev, el);
      issue(o, x, y, 0, lat, rb);
      checks++;
      if (obs() !== ev || lat !== el || rb) begin
        errs++;
        $display("FAIL rand%0d op%0d: got %h/%0d want %h/%0d",
                 i, o, obs(), lat, ev, el);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      retire(rdy, ov);
      checks++;
      if ({rdy, ov} !== 2'b10) begin
        errs++;
        $display("FAIL rand_ret%0d: got %b want 10",
                 i, {rdy, ov});
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_mul();
    test_illegal_ignore();
    test_hold();
    test_reset_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
